// File: rtl/cpu_step_controller.sv
// CPU clock-enable gate: turns slow_clk rises and debounced run/step buttons
// into single-cycle cpu_en pulses in the clk domain, with a halt freeze.
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             btn_mode,
    input  logic             btn_step,
    input  logic             halt,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        PAUSE  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    // slow_q[0]=s0, slow_q[1]=s1, slow_q[2]=s2 (edge-detect delay)
    logic [2:0]          slow_q;
    logic                tick;

    // Button index 0 is mode, 1 is step
    logic [1:0]          bsync0_q, bsync1_q;
    logic [1:0]          stable_q, stable_d;
    logic [1:0][DW-1:0]  dcnt_q, dcnt_d;
    logic [1:0]          press;

    state_t              state_q, state_d;
    logic                cpu_en_q, cpu_en_d;
    logic                running_q, running_d;
    logic                halted_q, halted_d;
    logic [CNT_W-1:0]    step_count_q, step_count_d;

    assign tick = slow_q[1] & ~slow_q[2];

    // A press fires on the same edge that the stable level rises
    always_comb begin
        stable_d = stable_q;
        dcnt_d   = '0;
        press    = '0;
        for (int i = 0; i < 2; i++) begin
            if (bsync1_q[i] != stable_q[i]) begin
                if (dcnt_q[i] == DB_LAST) begin
                    stable_d[i] = bsync1_q[i];
                    press[i]    = bsync1_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        if (halt) begin
            state_d = HALTED;
        end else begin
            unique case (state_q)
                PAUSE: begin
                    if (press[0])      state_d  = RUN;
                    else if (press[1]) cpu_en_d = 1'b1;
                end
                RUN: begin
                    cpu_en_d = tick;
                    if (press[0]) state_d = PAUSE;
                end
                HALTED: begin
                    if (press[0]) state_d = PAUSE;
                end
                default: state_d = PAUSE;
            endcase
        end
        running_d    = (state_d == RUN);
        halted_d     = (state_d == HALTED);
        step_count_d = step_count_q + CNT_W'(cpu_en_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slow_q       <= '0;
            bsync0_q     <= '0;
            bsync1_q     <= '0;
            stable_q     <= '0;
            dcnt_q       <= '0;
            state_q      <= PAUSE;
            cpu_en_q     <= 1'b0;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            slow_q       <= {slow_q[1:0], slow_clk};
            bsync0_q     <= {btn_step, btn_mode};
            bsync1_q     <= bsync0_q;
            stable_q     <= stable_d;
            dcnt_q       <= dcnt_d;
            state_q      <= state_d;
            cpu_en_q     <= cpu_en_d;
            running_q    <= running_d;
            halted_q     <= halted_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign running    = running_q;
    assign halted     = halted_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: directed scenarios plus random stimulus,
// every cycle compared against a history-based reference model.
module tb_cpu_step_controller;

    localparam int DB   = 4;
    localparam int CW   = 4;
    localparam int MOD  = 1 << CW;
    localparam int M_PAUSE  = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          slow_clk = 1'b0;
    logic          btn_mode = 1'b0;
    logic          btn_step = 1'b0;
    logic          halt = 1'b0;
    logic          cpu_en;
    logic          running;
    logic          halted;
    logic [CW-1:0] step_count;

    int n_checks = 0;
    int n_errors = 0;
    int npulse   = 0;

    // Reference model state
    int         m_st = M_PAUSE;
    int         m_en = 0;
    int         m_cnt = 0;
    logic [3:0] sl_h = '0;
    logic [3:0] bm_h = '0;
    logic [3:0] bs_h = '0;
    logic       m_stb = 1'b0;
    logic       s_stb = 1'b0;
    int         m_run = 0;
    int         s_run = 0;

    cpu_step_controller #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .slow_clk  (slow_clk),
        .btn_mode  (btn_mode),
        .btn_step  (btn_step),
        .halt      (halt),
        .cpu_en    (cpu_en),
        .running   (running),
        .halted    (halted),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp_v, $time);
        end
    endtask

    task automatic deb(input logic syn, inout logic stb, inout int run,
                       output logic pr);
        pr = 1'b0;
        if (syn != stb) begin
            run++;
            if (run == DB) begin
                stb = syn;
                run = 0;
                pr  = syn;
            end
        end else begin
            run = 0;
        end
    endtask

    // Called once per rising edge with the inputs sampled at that edge
    task automatic model_step();
        logic tk, mp, sp;
        int   en;
        if (!rst) begin
            m_st = M_PAUSE; m_en = 0; m_cnt = 0;
            sl_h = '0; bm_h = '0; bs_h = '0;
            m_stb = 1'b0; s_stb = 1'b0; m_run = 0; s_run = 0;
            return;
        end
        m_cnt = (m_cnt + m_en) % MOD;
        sl_h = {sl_h[2:0], slow_clk};
        bm_h = {bm_h[2:0], btn_mode};
        bs_h = {bs_h[2:0], btn_step};
        tk = sl_h[2] && !sl_h[3];
        deb(bm_h[2], m_stb, m_run, mp);
        deb(bs_h[2], s_stb, s_run, sp);
        en = 0;
        if (halt) m_st = M_HALTED;
        else if (m_st == M_PAUSE) begin
            if (mp) m_st = M_RUN;
            else if (sp) en = 1;
        end else if (m_st == M_RUN) begin
            en = tk ? 1 : 0;
            if (mp) m_st = M_PAUSE;
        end else begin
            if (mp) m_st = M_PAUSE;
        end
        m_en = en;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            check("cpu_en", cpu_en, m_en);
            check("running", running, m_st == M_RUN);
            check("halted", halted, m_st == M_HALTED);
            check("step_count", step_count, m_cnt);
            if (cpu_en === 1'b1) npulse++;
        end
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; cyc(10);
        btn_mode = 1'b0; cyc(8);
    endtask

    task automatic slow_rises(input int n);
        for (int i = 0; i < n; i++) begin
            slow_clk = 1'b1; cyc(4);
            slow_clk = 1'b0; cyc(4);
        end
    endtask

    initial begin
        int p0;

        // 1 reset / idle
        cyc(3);
        rst = 1'b1;
        npulse = 0;
        for (int i = 0; i < 3; i++) begin
            slow_clk = 1'b1; cyc(4);
            slow_clk = 1'b0; cyc(4);
        end
        check("t1_pulses", npulse, 0);
        check("t1_count", step_count, 0);
        check("t1_running", running, 0);

        // 2 debounce
        btn_step = 1'b1; cyc(2);
        btn_step = 1'b0; cyc(8);
        check("t2_short", step_count, 0);
        npulse = 0;
        btn_step = 1'b1; cyc(10);
        btn_step = 1'b0; cyc(8);
        check("t2_pulses", npulse, 1);
        check("t2_count", step_count, 1);

        // 3 run: first rise checked for exact latency
        press_mode();
        check("t3_running", running, 1);
        npulse = 0;
        slow_clk = 1'b1;
        cyc(1); check("t3_lat1", cpu_en, 0);
        cyc(1); check("t3_lat2", cpu_en, 0);
        cyc(1); check("t3_lat3", cpu_en, 1);
        cyc(1); check("t3_lat4", cpu_en, 0);
        slow_clk = 1'b0; cyc(4);
        slow_rises(4);
        check("t3_pulses", npulse, 5);
        check("t3_count", step_count, 6);

        // 4 halt
        halt = 1'b1;
        cyc(1);
        check("t4_halted", halted, 1);
        check("t4_running", running, 0);
        npulse = 0;
        slow_rises(2);
        press_mode();
        check("t4_ignored", halted, 1);
        check("t4_pulses", npulse, 0);
        halt = 1'b0; cyc(3);
        check("t4_stay", halted, 1);
        press_mode();
        check("t4_resume_h", halted, 0);
        check("t4_resume_r", running, 0);

        // 5 collision then wrap
        npulse = 0;
        btn_mode = 1'b1; btn_step = 1'b1; cyc(10);
        btn_mode = 1'b0; btn_step = 1'b0; cyc(8);
        check("t5_run", running, 1);
        check("t5_nopulse", npulse, 0);
        rst = 1'b0; cyc(2);
        rst = 1'b1; cyc(2);
        press_mode();
        slow_rises(17);
        check("t5_wrap", step_count, 1);

        // 6 async reset mid-run
        check("t6_pre", running, 1);
        #3;
        rst = 1'b0;
        #1;
        check("t6_en0", cpu_en, 0);
        check("t6_run0", running, 0);
        check("t6_halt0", halted, 0);
        check("t6_cnt0", step_count, 0);
        cyc(2);
        slow_clk = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(6);
        check("t6_pause", running, 0);
        press_mode();
        p0 = npulse;
        cyc(6);
        check("t6_nolevel", npulse - p0, 0);
        slow_clk = 1'b0; cyc(4);
        slow_clk = 1'b1; cyc(4);
        check("t6_rise", npulse - p0, 1);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) slow_clk = ~slow_clk;
            if ($urandom_range(0, 9) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 7) == 0) btn_step = ~btn_step;
            if ($urandom_range(0, 39) == 0) halt = ~halt;
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
